// File: rtl/kernel_pr_write_back_start_ctrl.sv
// Start controller for the write_back process: pops start tokens from a FWFT FIFO and
// runs the ap_start/ap_ready/ap_done/ap_continue handshake. KERNEL_PR_WB_TASK_CNT_EN adds task_cnt.
module kernel_pr_write_back_start_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty_n,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_read,
    output logic                  ap_start,
    input  logic                  ap_ready,
    input  logic                  ap_done,
    output logic                  ap_continue,
    output logic [DATA_WIDTH-1:0] token_out,
    output logic                  busy
`ifdef KERNEL_PR_WB_TASK_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  task_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  w_pop;
    logic                  w_done;
    logic [DATA_WIDTH-1:0] r_token;

    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("CNT_WIDTH must be at least 1");
    end
    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $error("DATA_WIDTH must be at least 1");
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a completion pops the next token in the same cycle when one is waiting
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (fifo_empty_n) begin
                    w_pop        = 1'b1;
                    w_next_state = S_START;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_START: begin
                if (ap_ready && ap_done) begin
                    w_done = 1'b1;
                    if (fifo_empty_n) begin
                        w_pop        = 1'b1;
                        w_next_state = S_START;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else if (ap_ready) begin
                    w_next_state = S_WAIT_DONE;
                end else begin
                    w_next_state = S_START;
                end
            end
            S_WAIT_DONE: begin
                if (ap_done) begin
                    w_done = 1'b1;
                    if (fifo_empty_n) begin
                        w_pop        = 1'b1;
                        w_next_state = S_START;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else begin
                    w_next_state = S_WAIT_DONE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output decode; the pop strobe is masked while reset is held
    always_comb begin
        fifo_read   = w_pop & ~reset;
        ap_start    = (r_state == S_START);
        ap_continue = (r_state != S_IDLE);
        busy        = (r_state != S_IDLE);
    end

    // Token latched on every pop, held until the next one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_token <= {DATA_WIDTH{1'b0}};
        end else if (w_pop) begin
            r_token <= fifo_dout;
        end else begin
            r_token <= r_token;
        end
    end

    assign token_out = r_token;

`ifdef KERNEL_PR_WB_TASK_CNT_EN
    logic [CNT_WIDTH-1:0] r_task_cnt;

    // Completed-task counter, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_task_cnt <= {CNT_WIDTH{1'b0}};
        end else if (w_done) begin
            r_task_cnt <= r_task_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_task_cnt <= r_task_cnt;
        end
    end

    assign task_cnt = r_task_cnt;
`endif

endmodule

// File: doc/kernel_pr_write_back_start_ctrl.md
KERNEL_PR_WRITE_BACK_START_CTRL -- requirements
Module: kernel_pr_write_back_start_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1, the width of a start token.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, the width of the completed-task counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port fifo_empty_n  input  1  start FIFO holds at least one token; first-word-fall-through.
REQ-006 SHALL have port fifo_dout  input  DATA_WIDTH  head token of the start FIFO, valid while fifo_empty_n=1.
REQ-007 SHALL have port fifo_read  output  1  one-cycle pop strobe to the start FIFO (read and read_ce tied together).
REQ-008 SHALL have port ap_start  output  1  start request to the write_back process.
REQ-009 SHALL have port ap_ready  input  1  process has accepted its start.
REQ-010 SHALL have port ap_done  input  1  process has finished its task.
REQ-011 SHALL have port ap_continue  output  1  permits the process to retire ap_done.
REQ-012 SHALL have port token_out  output  DATA_WIDTH  token latched at pop, held stable until the next pop.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port task_cnt  output  CNT_WIDTH  number of completed tasks (present only per REQ-030).

Function
REQ-015 SHALL implement the FSM states IDLE, START and WAIT_DONE.
REQ-016 In IDLE with fifo_empty_n=1, SHALL assert fifo_read combinationally for that cycle, latch fifo_dout into token_out, and enter START.
REQ-017 SHALL never assert fifo_read while fifo_empty_n=0, and SHALL never assert it outside IDLE, except as permitted by REQ-020.
REQ-018 SHALL drive ap_start=1 exactly while in START, with a latency of 1 cycle from pop to ap_start.
REQ-019 In START, ap_ready=1 with ap_done=0 SHALL move the FSM to WAIT_DONE; ap_start SHALL be low the following cycle.
REQ-020 In WAIT_DONE with ap_done=1: SHALL count one task; with fifo_empty_n=1, SHALL pop and latch the next token and return to START (back-to-back, no IDLE bubble); otherwise SHALL return to IDLE.
REQ-021 In START, ap_ready=1 together with ap_done=1 SHALL complete the task in the same cycle, following REQ-020 rules for the next state.
REQ-022 SHALL drive ap_continue=1 in START and WAIT_DONE, and ap_continue=0 in IDLE.
REQ-023 SHALL ignore ap_done and ap_ready while in IDLE (no count, no state change).
REQ-024 SHALL ignore ap_done while in START without ap_ready; ap_start SHALL stay high.
REQ-025 SHALL increment task_cnt by 1 per completed task and wrap modulo 2^CNT_WIDTH.

Reset
REQ-026 SHALL, on reset assertion, immediately force state=IDLE, fifo_read=0, ap_start=0, ap_continue=0, busy=0, token_out=0 and task_cnt=0, without waiting for a clock edge.
REQ-027 SHALL abandon any in-flight task on reset mid-operation; that token is lost and not counted.
REQ-028 SHALL hold all outputs at their reset values while reset=1, regardless of fifo_empty_n.

Configuration
REQ-029 SHALL use the macro KERNEL_PR_WB_TASK_CNT_EN to control the task counter.
REQ-030 With KERNEL_PR_WB_TASK_CNT_EN defined, SHALL implement the task_cnt port and its counter; without it, SHALL omit both the port and the counter register, and all other behaviour SHALL be identical.

Verification
REQ-031 Single token: reset released, push token 1, ready at ap_start cycle 2, done 3 cycles later -> one fifo_read pulse, ap_start high 2 cycles, task_cnt=1, FSM ends in IDLE.
REQ-032 Back-to-back: 3 tokens queued, ready and done each 1 cycle after entry -> 3 pops, no IDLE cycle between tasks, token_out sequence matches queue order, task_cnt=3.
REQ-033 Combinational process: ap_ready=ap_done=1 in first START cycle -> ap_start high exactly 1 cycle, task counted, next pop in same cycle if FIFO non-empty.
REQ-034 Empty FIFO: fifo_empty_n=0 for 20 cycles, spurious ap_done pulses -> fifo_read never high, task_cnt stays 0, busy=0.
REQ-035 Reset mid-task: assert reset asynchronously in WAIT_DONE -> ap_start/ap_continue/busy low before next edge, task_cnt=0, no pop until reset deasserts.
REQ-036 Wrap, counter-enabled build with CNT_WIDTH=4: complete 17 tasks -> task_cnt=1; same stimulus without the macro -> identical fifo_read/ap_start traces.
